if_id_queue: RTL and testbench

- Parametrised successor of the IF/ID pipeline register.
- Holds fetched instructions in a DEPTH-entry FIFO between fetch and decode, with a valid/ready handshake on both sides and a flush input for branch redirect.
- Splits the head instruction into MIPS fields and extends the immediate according to opcode.
- Lets fetch run ahead of a stalled decode stage without losing instructions.

---
 rtl/if_id_queue_if.sv | 35 +++
 rtl/if_id_queue.sv | 143 ++++++++++++++
 tb/tb_if_id_queue.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/if_id_queue_if.sv
// IF/ID queue handshake bundle: fetch push side and decode pop side.
// The queue takes the slave modport; the fetch/decode environment takes master.
interface if_id_queue_if #(
  parameter int ADDR_W = 32
);
  logic              if_valid;
  logic              if_ready;
  logic [ADDR_W-1:0] if_pc;
  logic [31:0]       if_inst;
  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] id_pc;
  logic [5:0]        id_opcode;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic [4:0]        id_sa;
  logic [5:0]        id_fn;
  logic [31:0]       id_imm;
  logic [25:0]       id_target;

  modport slave (
    input  if_valid, if_pc, if_inst, id_ready,
    output if_ready, id_valid, id_pc, id_opcode,
    output id_rs, id_rt, id_rd, id_sa, id_fn,
    output id_imm, id_target
  );

  modport master (
    output if_valid, if_pc, if_inst, id_ready,
    input  if_ready, id_valid, id_pc, id_opcode,
    input  id_rs, id_rt, id_rd, id_sa, id_fn,
    input  id_imm, id_target
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry FIFO with flush and head decode.
// Optional perf counters built only when IF_ID_PERF_CNT_EN is defined.
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  if_id_queue_if.slave     bus,
  output logic [CNT_W-1:0] occupancy,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      bubble_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [31:0]       inst_mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic full, empty, push, pop;
  logic [ADDR_W-1:0] head_pc;
  logic [31:0]       head_inst;
  logic              is_zext, is_lui;

  assign full  = (cnt_q == FULL);
  assign empty = (cnt_q == '0);
  assign push  = bus.if_valid && !full && !flush;
  assign pop   = !empty && bus.id_ready && !flush;

  assign bus.if_ready = !full;
  assign bus.id_valid = !empty;
  assign occupancy    = cnt_q;

  // Next pointer/count; flush drops everything, including the offer.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; contents need no reset since empty heads read as 0.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem_q[wr_ptr_q]   <= bus.if_pc;
      inst_mem_q[wr_ptr_q] <= bus.if_inst;
    end
  end

  // Head entry, forced to zero when the queue is empty.
  always_comb begin
    head_pc   = '0;
    head_inst = '0;
    if (!empty) begin
      head_pc   = pc_mem_q[rd_ptr_q];
      head_inst = inst_mem_q[rd_ptr_q];
    end
  end

  assign bus.id_pc     = head_pc;
  assign bus.id_opcode = head_inst[31:26];
  assign bus.id_rs     = head_inst[25:21];
  assign bus.id_rt     = head_inst[20:16];
  assign bus.id_rd     = head_inst[15:11];
  assign bus.id_sa     = head_inst[10:6];
  assign bus.id_fn     = head_inst[5:0];
  assign bus.id_target = head_inst[25:0];

  assign is_zext = (head_inst[31:26] == 6'h0C) ||
                   (head_inst[31:26] == 6'h0D) ||
                   (head_inst[31:26] == 6'h0E);
  assign is_lui  = (head_inst[31:26] == 6'h0F);

  // Immediate: logical ops zero-extend, LUI shifts, rest sign-extend.
  always_comb begin
    bus.id_imm = {{16{head_inst[15]}}, head_inst[15:0]};
    unique case (1'b1)
      is_zext: bus.id_imm = {16'h0, head_inst[15:0]};
      is_lui:  bus.id_imm = {head_inst[15:0], 16'h0};
      default: bus.id_imm = {{16{head_inst[15]}}, head_inst[15:0]};
    endcase
  end

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] bubble_q, bubble_d;

  // Stall/bubble increments; flush does not disturb them.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (!empty && !bus.id_ready) stall_d = stall_q + 32'd1;
    if (empty) bubble_d = bubble_q + 32'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = 32'h0;
  assign bubble_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed steps plus random traffic,
// checked against a queue-based reference model.
module tb_if_id_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [2:0]  occupancy;
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;

  int checks   = 0;
  int failures = 0;

  logic [63:0] mq[$];
  int unsigned m_stall;
  int unsigned m_bubble;

  if_id_queue_if #(.ADDR_W(32)) bus ();

  if_id_queue #(
    .ADDR_W(32),
    .DEPTH (DEPTH),
    .CNT_W (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_imm(logic [31:0] inst);
    logic [5:0]  op;
    logic [15:0] i16;
    op  = inst[31:26];
    i16 = inst[15:0];
    if (op == 6'h0C || op == 6'h0D || op == 6'h0E)
      return {16'h0, i16};
    if (op == 6'h0F)
      return {i16, 16'h0};
    return {{16{i16[15]}}, i16};
  endfunction

  task automatic compare();
    logic [31:0] pc, inst;
    bit          v;
    v    = (mq.size() != 0);
    pc   = v ? mq[0][63:32] : 32'h0;
    inst = v ? mq[0][31:0]  : 32'h0;
    chk("occupancy", 32'(occupancy), 32'(mq.size()));
    chk("if_ready", 32'(bus.if_ready), 32'(mq.size() != DEPTH));
    chk("id_valid", 32'(bus.id_valid), 32'(v));
    chk("id_pc", bus.id_pc, pc);
    chk("id_opcode", 32'(bus.id_opcode), inst >> 26);
    chk("id_rs", 32'(bus.id_rs), (inst >> 21) & 32'h1F);
    chk("id_rt", 32'(bus.id_rt), (inst >> 16) & 32'h1F);
    chk("id_rd", 32'(bus.id_rd), (inst >> 11) & 32'h1F);
    chk("id_sa", 32'(bus.id_sa), (inst >> 6) & 32'h1F);
    chk("id_fn", 32'(bus.id_fn), inst & 32'h3F);
    chk("id_target", 32'(bus.id_target), inst & 32'h03FF_FFFF);
    chk("id_imm", bus.id_imm, exp_imm(inst));
`ifdef IF_ID_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("bubble_cnt", bubble_cnt, m_bubble);
`else
    chk("stall_cnt", stall_cnt, 32'h0);
    chk("bubble_cnt", bubble_cnt, 32'h0);
`endif
  endtask

  task automatic step(bit r, bit f, bit v,
                      logic [31:0] pc, logic [31:0] inst, bit rdy);
    bit do_pop, do_push;
    rst          = r;
    flush        = f;
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_inst  = inst;
    bus.id_ready = rdy;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if (mq.size() != 0 && !rdy) m_stall++;
      if (mq.size() == 0) m_bubble++;
      do_pop  = (mq.size() != 0) && rdy && !f;
      do_push = v && (mq.size() != DEPTH) && !f;
      if (f) mq.delete();
      else begin
        if (do_pop)  void'(mq.pop_front());
        if (do_push) mq.push_back({pc, inst});
      end
    end
    #1;
    compare();
  endtask

  task automatic idle(bit rdy);
    step(0, 0, 0, 32'h0, 32'h0, rdy);
  endtask

  initial begin
    logic [5:0]  ops[8];
    logic [31:0] ri, rp;
    ops = '{6'h00, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h04};
    rst = 1'b1;
    flush = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_pc = '0;
    bus.if_inst = '0;
    bus.id_ready = 1'b0;
    m_stall = 0;
    m_bubble = 0;

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(0);
    chk("rst_valid", 32'(bus.id_valid), 32'h0);
    chk("rst_imm", bus.id_imm, 32'h0);
    chk("rst_occ", 32'(occupancy), 32'h0);
    chk("rst_ready", 32'(bus.if_ready), 32'h1);

    step(0, 0, 1, 32'h100, 32'h2408FFFF, 0);
    chk("single_valid", 32'(bus.id_valid), 32'h1);
    chk("single_pc", bus.id_pc, 32'h100);
    chk("single_op", 32'(bus.id_opcode), 32'h09);
    chk("single_rt", 32'(bus.id_rt), 32'h8);
    chk("single_imm", bus.id_imm, 32'hFFFFFFFF);
    idle(1);
    chk("single_popped", 32'(bus.id_valid), 32'h0);

    for (int i = 0; i < 4; i++)
      step(0, 0, 1, 32'(i * 4), 32'h0000_0000 | 32'(i), 0);
    chk("fill_occ", 32'(occupancy), 32'h4);
    chk("fill_ready", 32'(bus.if_ready), 32'h0);
    step(0, 0, 1, 32'h10, 32'h3C01_1234, 0);
    chk("fifth_occ", 32'(occupancy), 32'h4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", bus.id_pc, 32'(i * 4));
      idle(1);
    end
    chk("drain_empty", 32'(bus.id_valid), 32'h0);

    step(0, 0, 1, 32'h200, 32'h8C01_0001, 0);
    step(0, 0, 1, 32'h204, 32'h8C01_0002, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 32'h208 + 32'(i * 4), 32'h0000_0020, 1);
      chk("wrap_occ", 32'(occupancy), 32'h2);
    end
    chk("wrap_head", bus.id_pc, 32'h228);

    idle(1);
    idle(1);
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 32'h300 + 32'(i * 4), 32'h0000_0000, 0);
    step(0, 1, 1, 32'hDEAD0, 32'h2402_0007, 1);
    chk("flush_occ", 32'(occupancy), 32'h0);
    chk("flush_valid", 32'(bus.id_valid), 32'h0);
    step(0, 0, 1, 32'h400, 32'h0000_0000, 0);
    chk("redirect_pc", bus.id_pc, 32'h400);
    idle(1);

    step(0, 0, 1, 32'h500, 32'h3401_8000, 0);
    chk("imm_ori", bus.id_imm, 32'h00008000);
    idle(1);
    step(0, 0, 1, 32'h504, 32'h3C01_1234, 0);
    chk("imm_lui", bus.id_imm, 32'h12340000);
    idle(1);
    step(0, 0, 1, 32'h508, 32'h8C01_8000, 0);
    chk("imm_lw", bus.id_imm, 32'hFFFF8000);
    idle(1);

    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h600, 32'h0000_0000, 0);
    for (int i = 0; i < 5; i++) idle(0);
`ifdef IF_ID_PERF_CNT_EN
    chk("stall5", stall_cnt, 32'd5);
`else
    chk("stall5", stall_cnt, 32'd0);
`endif
    idle(1);

    for (int i = 0; i < 400; i++) begin
      ri = $urandom;
      ri[31:26] = ops[$urandom_range(0, 7)];
      rp = $urandom & 32'hFFFF_FFFC;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0), rp, ri,
           ($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
